// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, fetch FSM states and the IF/ID payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;

    localparam logic [OPW-1:0] FN_ADD = 6'h20;
    localparam logic [OPW-1:0] FN_SUB = 6'h22;
    localparam logic [OPW-1:0] FN_AND = 6'h24;
    localparam logic [OPW-1:0] FN_OR  = 6'h25;
    localparam logic [OPW-1:0] FN_SLT = 6'h2A;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {instr, pc+4} that arrived while decode was stalled.
module fetch_skid_buffer
    import mips_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic         o_full,
    output fetch_entry_t o_entry
);

    logic         r_full;
    fetch_entry_t r_entry;

    // Clear wins; a push alongside a pop refills the slot.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, imem request/ack handshake, IF/ID register, stall skid and branch/jump redirect.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_ack_in,
    input  logic [XLEN-1:0] imem_data_in,
    input  logic            stall_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            jump_in,
    output logic            valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [5:0]      op_out,
    output logic [5:0]      func_out,
    output logic [4:0]      rs_out,
    output logic [4:0]      rt_out,
    output logic [4:0]      rd_out,
    output logic [15:0]     imm_out,
    output logic [XLEN-1:0] pc_plus4_out
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_addr, w_addr_nxt;
    logic            r_req, w_req_nxt;
    logic            r_valid, w_valid_nxt;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic [XLEN-1:0] r_pc4, w_pc4_nxt;

    logic            w_ack, w_redirect;
    logic [XLEN-1:0] w_pc_inc, w_target;
    logic            w_push, w_pop, w_clear, w_skid_full, w_full_nxt;
    fetch_entry_t    w_skid_in, w_skid_out;

    assign w_ack      = r_req & imem_ack_in;
    assign w_redirect = r_valid & (branch_taken_in | jump_in);
    assign w_pc_inc   = r_pc + XLEN'(4);
    assign w_target   = branch_taken_in ? (branch_target_in & 32'hFFFF_FFFC)
                                        : {r_pc4[31:28], r_instr[25:0], 2'b00};
    assign w_skid_in  = '{instr: imem_data_in, pc4: w_pc_inc};

    fetch_skid_buffer u_skid (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_entry (w_skid_in),
        .o_full  (w_skid_full),
        .o_entry (w_skid_out)
    );

    // Next-state, PC and IF/ID update.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;

        unique case (r_state)
            FS_IDLE: w_state_nxt = FS_FETCH;
            FS_FETCH: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INSTR;
                    w_clear     = 1'b1;
                    if (r_req && !imem_ack_in) begin
                        w_state_nxt = FS_DRAIN;
                    end
                end else if (stall_in) begin
                    if (w_ack) begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end
                end else begin
                    if (w_skid_full) begin
                        w_valid_nxt = 1'b1;
                        w_instr_nxt = w_skid_out.instr;
                        w_pc4_nxt   = w_skid_out.pc4;
                        w_pop       = 1'b1;
                        w_push      = w_ack;
                    end else if (w_ack) begin
                        w_valid_nxt = 1'b1;
                        w_instr_nxt = imem_data_in;
                        w_pc4_nxt   = w_pc_inc;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_instr_nxt = NOP_INSTR;
                    end
                    if (w_ack) begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            FS_DRAIN: begin
                if (w_ack) begin
                    w_state_nxt = FS_FETCH;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase

        w_full_nxt = w_clear ? 1'b0 : (w_push ? 1'b1 : (w_pop ? 1'b0 : w_skid_full));
        // A wrong-path request keeps its address until the memory answers it.
        w_req_nxt  = (w_state_nxt == FS_DRAIN) || ((w_state_nxt == FS_FETCH) && !w_full_nxt);
        w_addr_nxt = (w_state_nxt == FS_DRAIN) ? r_addr : w_pc_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
        end
    end

    assign imem_req_out  = r_req;
    assign imem_addr_out = r_addr;
    assign valid_out     = r_valid;
    assign instr_out     = r_instr;
    assign pc_plus4_out  = r_pc4;
    assign op_out        = r_instr[31:26];
    assign rs_out        = r_instr[25:21];
    assign rt_out        = r_instr[20:16];
    assign rd_out        = r_instr[15:11];
    assign func_out      = r_instr[5:0];
    assign imm_out       = r_instr[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Random-stimulus bench: program-order PC model feeds an expected queue, a monitor checks IF/ID and the imem protocol.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int unsigned N_CYCLES = 3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in, imem_req_out, imem_ack_in, stall_in, branch_taken_in, jump_in, valid_out;
    logic [31:0] imem_addr_out, imem_data_in, branch_target_in, instr_out, pc_plus4_out;
    logic [5:0]  op_out, func_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [15:0] imm_out;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        last_exp;
    exp_t        mon_e;
    bit          shown, flush_chk, proto_en;
    logic        last_req;
    logic [31:0] last_addr;
    int unsigned n_deliv, last_deliv;
    int          idle, mem_wait, stall_left;
    bit          mem_busy, did_reset;
    logic [31:0] tgt_list [4] = '{32'h0000_0042, 32'h1000_0004, 32'hFFFF_FFF0, 32'h0000_0000};

    always #5 clk_in = ~clk_in;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ack_in      (imem_ack_in),
        .imem_data_in     (imem_data_in),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .jump_in          (jump_in),
        .valid_out        (valid_out),
        .instr_out        (instr_out),
        .op_out           (op_out),
        .func_out         (func_out),
        .rs_out           (rs_out),
        .rt_out           (rt_out),
        .rd_out           (rd_out),
        .imm_out          (imm_out),
        .pc_plus4_out     (pc_plus4_out)
    );

    // Instruction memory image: LW at 0, J 0x10 at 0x1000_0004, hashed words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h8C22_0004;
        if (a == 32'h1000_0004) return 32'h0800_0010;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: protocol rules and IF/ID contents against the expected queue.
    always @(negedge clk_in) begin
        if (proto_en) begin
            if (last_req && rst_n_in && !imem_ack_in)
                check(imem_req_out && imem_addr_out == last_addr, "req_hold", imem_addr_out, last_addr);
            if (imem_req_out)
                check(imem_addr_out[1:0] == 2'b00, "addr_align", imem_addr_out, imem_addr_out & 32'hFFFF_FFFC);
            if (flush_chk) begin
                check(!valid_out && instr_out == NOP_INSTR, "flush", instr_out, NOP_INSTR);
                flush_chk = 1'b0;
            end
            if (valid_out && !shown) begin
                shown = 1'b1;
                n_deliv++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_instr", instr_out, 32'h0);
                end else begin
                    mon_e    = exp_q.pop_front();
                    last_exp = mon_e;
                    check(instr_out == mon_e.instr, "instr", instr_out, mon_e.instr);
                    check(pc_plus4_out == mon_e.pc4, "pc_plus4", pc_plus4_out, mon_e.pc4);
                    check({op_out, rs_out, rt_out, rd_out, func_out} == {mon_e.instr[31:11], mon_e.instr[5:0]},
                          "fields", {5'b0, op_out, rs_out, rt_out, rd_out, func_out},
                          {5'b0, mon_e.instr[31:11], mon_e.instr[5:0]});
                    check(imm_out == mon_e.instr[15:0], "imm", {16'h0, imm_out}, {16'h0, mon_e.instr[15:0]});
                end
            end else if (valid_out) begin
                check(instr_out == last_exp.instr && pc_plus4_out == last_exp.pc4, "hold",
                      instr_out, last_exp.instr);
            end
        end
        last_req  = imem_req_out;
        last_addr = imem_addr_out;
    end

    // Called after a reset edge: check reset state, restart the model, release reset with a stray ack.
    task automatic reset_and_release();
        check(!valid_out, "rst_valid", {31'h0, valid_out}, 32'h0);
        check(instr_out == NOP_INSTR, "rst_instr", instr_out, NOP_INSTR);
        check(pc_plus4_out == 32'h0, "rst_pc4", pc_plus4_out, 32'h0);
        check(!imem_req_out, "rst_req", {31'h0, imem_req_out}, 32'h0);
        exp_q.delete();
        exp_q.push_back('{instr: mem_word(RST_PC), pc4: RST_PC + 32'd4});
        shown = 1'b0; flush_chk = 1'b0; mem_busy = 1'b0; stall_left = 0; idle = 0;
        rst_n_in = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0; jump_in = 1'b0;
        imem_ack_in = 1'b1; imem_data_in = 32'hDEAD_BEEF;
        @(negedge clk_in); #1;
        check(imem_req_out == 1'b1, "first_req", {31'h0, imem_req_out}, 32'h1);
        check(imem_addr_out == RST_PC, "first_addr", imem_addr_out, RST_PC);
    endtask

    // One cycle of memory response, stall and redirect stimulus plus the program-order model.
    task automatic step();
        exp_t        cur;
        logic [31:0] nxt, tgt;
        if (n_deliv != last_deliv) begin
            last_deliv = n_deliv;
            idle = 0;
        end else begin
            idle++;
            if (idle > 40) begin
                check(1'b0, "watchdog", n_deliv, last_deliv + 1);
                idle = 0;
            end
        end

        imem_ack_in  = 1'b0;
        imem_data_in = $urandom;
        if (imem_req_out) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, 3);
            end
            if (mem_wait == 0) begin
                imem_ack_in  = 1'b1;
                imem_data_in = mem_word(imem_addr_out);
                mem_busy     = 1'b0;
            end else begin
                mem_wait--;
            end
        end

        if (stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 4);
        stall_in = (stall_left > 0);
        if (stall_left > 0) stall_left--;

        branch_taken_in = 1'b0;
        jump_in         = 1'b0;
        tgt = tgt_list[$urandom_range(0, 3)];
        if (tgt == 32'h0) tgt = $urandom;
        branch_target_in = tgt;
        cur = last_exp;

        if (valid_out && shown) begin
            if (cur.pc4 == 32'h1000_0008) begin
                jump_in  = 1'b1;
                stall_in = 1'b1;
            end else begin
                case ($urandom_range(0, 15))
                    0: branch_taken_in = 1'b1;
                    1: jump_in = 1'b1;
                    2: begin branch_taken_in = 1'b1; jump_in = 1'b1; end
                    default: ;
                endcase
            end
            if (!stall_in || branch_taken_in || jump_in) begin
                if (branch_taken_in)  nxt = tgt & 32'hFFFF_FFFC;
                else if (jump_in)     nxt = {cur.pc4[31:28], cur.instr[25:0], 2'b00};
                else                  nxt = cur.pc4;
                flush_chk = branch_taken_in || jump_in;
                shown     = 1'b0;
                exp_q.push_back('{instr: mem_word(nxt), pc4: nxt + 32'd4});
            end
        end else if ($urandom_range(0, 5) == 0) begin
            branch_taken_in = 1'b1;
            jump_in         = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst_n_in = 1'b0; imem_ack_in = 1'b0; imem_data_in = '0; stall_in = 1'b0;
        branch_taken_in = 1'b0; jump_in = 1'b0; branch_target_in = '0;
        shown = 1'b0; flush_chk = 1'b0; proto_en = 1'b0; last_req = 1'b0; last_addr = '0;
        n_deliv = 0; last_deliv = 0; idle = 0; mem_wait = 0; stall_left = 0;
        mem_busy = 1'b0; did_reset = 1'b0; last_exp = '0;
        repeat (2) @(negedge clk_in);
        #1;
        proto_en = 1'b1;
        reset_and_release();
        for (int cyc = 0; cyc < int'(N_CYCLES); cyc++) begin
            if (!did_reset && cyc >= int'(N_CYCLES / 2) && imem_req_out) begin
                did_reset = 1'b1;
                rst_n_in = 1'b0; imem_ack_in = 1'b0; stall_in = 1'b0;
                branch_taken_in = 1'b0; jump_in = 1'b0;
                @(negedge clk_in); #1;
                reset_and_release();
            end
            step();
            @(negedge clk_in); #1;
        end
        check(n_deliv >= 200, "throughput", n_deliv, 32'd200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
